// File: rtl/zero_count_serial.sv
// Serial zero/one counter: examines CHUNK bits of a latched word per clock
// and returns the match count over a valid/ready output handshake.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | in_ready high, waiting for a word
// S_BUSY | consuming CHUNK bits per cycle from the shift register
// S_DONE | count presented with out_valid, held until out_ready
module zero_count_serial #(
  parameter  int WIDTH = 8,
  parameter  int CHUNK = 2,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int NBEAT  = WIDTH / CHUNK;
  localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_chk
    $error("zero_count_serial: CHUNK must divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  shreg_q;
  logic              mode_q;
  logic [CNT_W-1:0]  acc_q;
  logic [BEAT_W-1:0] beat_q;
  logic [CNT_W-1:0]  count_q;
  logic              out_valid_q;
  logic              in_ready_q;

  logic [CHUNK-1:0]  chunk_match;
  logic [CNT_W-1:0]  chunk_pop;
  logic [CNT_W-1:0]  acc_d;

  // Inverting for mode=0 lets one popcount serve both zero and one counting.
  always_comb begin
    chunk_match = mode_q ? shreg_q[CHUNK-1:0] : ~shreg_q[CHUNK-1:0];
    chunk_pop   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_pop = chunk_pop + CNT_W'(chunk_match[i]);
    end
    acc_d = acc_q + chunk_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      beat_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            shreg_q    <= data;
            mode_q     <= mode;
            acc_q      <= '0;
            beat_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q   <= acc_d;
          shreg_q <= shreg_q >> CHUNK;
          beat_q  <= beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            count_q     <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // in_valid is deliberately ignored here; acceptance waits for IDLE.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_zero_count_serial.sv
// Bench for zero_count_serial: four parameterisations checked against a
// bit-by-bit reference count, plus handshake, hold and reset scenarios.
module tb_zero_count_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] in_valid_v;
  logic [3:0] mode_v;
  logic [3:0] out_ready_v;
  wire  [3:0] in_ready_v;
  wire  [3:0] out_valid_v;

  logic [7:0]  d0, d2, d3;
  logic [15:0] d1;
  wire  [3:0]  c0, c2, c3;
  wire  [4:0]  c1;

  int total = 0;
  int bad   = 0;

  zero_count_serial #(.WIDTH(8), .CHUNK(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .data(d0), .mode(mode_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .count(c0));
  zero_count_serial #(.WIDTH(16), .CHUNK(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .data(d1), .mode(mode_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .count(c1));
  zero_count_serial #(.WIDTH(8), .CHUNK(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .data(d2), .mode(mode_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .count(c2));
  zero_count_serial #(.WIDTH(8), .CHUNK(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .data(d3), .mode(mode_v[3]), .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
    .count(c3));

  function automatic int width_of(input int u);
    return (u == 1) ? 16 : 8;
  endfunction

  function automatic int nbeat_of(input int u);
    case (u)
      0: return 4;
      1: return 4;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: walk every bit of the word and count those equal to mode.
  function automatic int ref_count(input logic [15:0] d, input int w, input logic m);
    int n = 0;
    for (int i = 0; i < w; i++) if (d[i] == m) n++;
    return n;
  endfunction

  function automatic logic [4:0] get_count(input int u);
    case (u)
      0: return {1'b0, c0};
      1: return c1;
      2: return {1'b0, c2};
      default: return {1'b0, c3};
    endcase
  endfunction

  task automatic set_in(input int u, input logic [15:0] d, input logic m);
    case (u)
      0: d0 = d[7:0];
      1: d1 = d;
      2: d2 = d[7:0];
      default: d3 = d[7:0];
    endcase
    mode_v[u] = m;
  endtask

  task automatic wait_out(input int u, output int lat);
    lat = 0;
    while (!out_valid_v[u] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Stimulus only: one word through unit u, returning count and latency.
  task automatic exchange(input int u, input logic [15:0] d, input logic m,
                          output logic [4:0] cnt, output int lat);
    int w = 0;
    while (!in_ready_v[u] && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    set_in(u, d, m);
    in_valid_v[u] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[u] = 1'b0;
    wait_out(u, lat);
    cnt = get_count(u);
    out_ready_v[u] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[u] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready_v[0] !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_v[0]); end
    total++; if (out_valid_v[0] !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid_v[0]); end
    total++; if (c0 !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", c0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [4:0] cnt;
    int lat;
    exchange(0, 16'h0000, 1'b0, cnt, lat);
    total++; if (cnt !== 5'd8) begin bad++; $display("FAIL basic_00 got=%0d want=8", cnt); end
    total++; if (lat !== 4) begin bad++; $display("FAIL basic_00_latency got=%0d want=4", lat); end
    exchange(0, 16'h00FF, 1'b0, cnt, lat);
    total++; if (cnt !== 5'd0) begin bad++; $display("FAIL basic_ff got=%0d want=0", cnt); end
  endtask

  task automatic test_thermometer;
    logic [4:0] cnt;
    int lat;
    logic [15:0] d;
    for (int k = 0; k <= 8; k++) begin
      d = (16'h0001 << k) - 16'h0001;
      exchange(0, d, 1'b0, cnt, lat);
      total++;
      if (cnt !== 5'(8 - k)) begin bad++; $display("FAIL thermo_%0d got=%0d want=%0d", k, cnt, 8 - k); end
    end
  endtask

  task automatic test_mode_ones;
    logic [4:0] cnt;
    int lat;
    exchange(0, 16'h00A5, 1'b1, cnt, lat);
    total++; if (cnt !== 5'd4) begin bad++; $display("FAIL ones_a5 got=%0d want=4", cnt); end
    exchange(0, 16'h0081, 1'b1, cnt, lat);
    total++; if (cnt !== 5'd2) begin bad++; $display("FAIL ones_81 got=%0d want=2", cnt); end
  endtask

  // Inputs wiggle in flight; a DONE-cycle in_valid must wait for IDLE.
  task automatic test_back_to_back;
    int lat;
    set_in(0, 16'h00A5, 1'b1);
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    set_in(0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    total++; if (in_ready_v[0] !== 1'b0) begin bad++; $display("FAIL busy_in_ready got=%b want=0", in_ready_v[0]); end
    set_in(0, 16'h00FF, 1'b1);
    wait_out(0, lat);
    total++; if (c0 !== 4'd4) begin bad++; $display("FAIL inflight_count got=%0d want=4", c0); end
    total++; if (lat !== 3) begin bad++; $display("FAIL inflight_latency got=%0d want=3", lat); end
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
    total++; if (out_valid_v[0] !== 1'b0) begin bad++; $display("FAIL b2b_out_valid got=%b want=0", out_valid_v[0]); end
    total++; if (in_ready_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_not_accepted got=%b want=1", in_ready_v[0]); end
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    total++; if (in_ready_v[0] !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b want=0", in_ready_v[0]); end
    wait_out(0, lat);
    total++; if (c0 !== 4'd8) begin bad++; $display("FAIL b2b_count got=%0d want=8", c0); end
    total++; if (lat !== 4) begin bad++; $display("FAIL b2b_latency got=%0d want=4", lat); end
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
  endtask

  task automatic test_hold;
    int lat;
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
    total++; if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
      bad++; $display("FAIL idle_out_ready got=%b%b want=10", in_ready_v[0], out_valid_v[0]);
    end
    set_in(0, 16'h000F, 1'b1);
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    wait_out(0, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid_v[0] !== 1'b1 || c0 !== 4'd4 || in_ready_v[0] !== 1'b0) begin
        bad++; $display("FAIL hold_%0d got=v%b c%0d r%b want=v1 c4 r0", i, out_valid_v[0], c0, in_ready_v[0]);
      end
    end
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
    total++; if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      bad++; $display("FAIL hold_release got=v%b r%b want=v0 r1", out_valid_v[0], in_ready_v[0]);
    end
  endtask

  task automatic test_reset_mid;
    logic [4:0] cnt;
    int lat;
    set_in(0, 16'h0000, 1'b0);
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid_v[0] !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid_v[0]); end
    total++; if (c0 !== 4'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", c0); end
    total++; if (in_ready_v[0] !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready_v[0]); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exchange(0, 16'h003C, 1'b1, cnt, lat);
    total++; if (cnt !== 5'd4) begin bad++; $display("FAIL after_rst_count got=%0d want=4", cnt); end
    total++; if (lat !== 4) begin bad++; $display("FAIL after_rst_latency got=%0d want=4", lat); end
  endtask

  task automatic test_params;
    logic [4:0] cnt;
    int lat;
    logic [15:0] d;
    logic m;
    int exp;
    exchange(1, 16'h00F0, 1'b0, cnt, lat);
    total++; if (cnt !== 5'd12) begin bad++; $display("FAIL w16_count got=%0d want=12", cnt); end
    total++; if (lat !== 4) begin bad++; $display("FAIL w16_latency got=%0d want=4", lat); end
    for (int u = 0; u < 4; u++) begin
      for (int n = 0; n < 12; n++) begin
        d = 16'($urandom);
        if (width_of(u) == 8) d[15:8] = 8'h00;
        m = 1'($urandom_range(0, 1));
        exp = ref_count(d, width_of(u), m);
        exchange(u, d, m, cnt, lat);
        total++;
        if (cnt !== 5'(exp)) begin bad++; $display("FAIL rand_u%0d d=%h m=%b got=%0d want=%0d", u, d, m, cnt, exp); end
        total++;
        if (lat !== nbeat_of(u)) begin bad++; $display("FAIL rand_latency_u%0d got=%0d want=%0d", u, lat, nbeat_of(u)); end
      end
    end
  endtask

  initial begin
    in_valid_v  = '0;
    mode_v      = '0;
    out_ready_v = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    test_reset;
    test_basic;
    test_thermometer;
    test_mode_ones;
    test_back_to_back;
    test_hold;
    test_reset_mid;
    test_params;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
